instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Sequential instruction encoder: the inverse of the 9-bit instruction decoder.
- Accepts symbolic instructions (mnemonic code plus register and immediate fields) over a valid/ready handshake.
- Range-checks each field, packs it into a 9-bit word, and writes the word to instruction memory at an auto-incrementing address.
- Used by the testbench and program-load path to build instruction memory images; stops after HALT or when memory is full.

Parameters:
- num_regs, 12, register file size; register fields are $clog2(num_regs) = 4 bits wide.
- instr_width, 9, encoded instruction width.
- imem_depth, 256, instruction memory words; addr_w = $clog2(imem_depth).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; IDLE/DONE -> RUN, loads write address from base_addr.
- base_addr  input  addr_w  first write address, sampled on start.
- in_valid  input  1  symbolic instruction present.
- in_ready  output  1  encoder accepts this cycle.
- mnem  input  4  0 AND, 1 SLT, 2 OR, 3 JR, 4 LW, 5 SW, 6 ADD, 7 ADDI, 8 TR1, 9 TR2, 15 HALT; all other codes are illegal.
- rs, rt, rd  input  4 each  register numbers.
- imm  input  3  immediate.
- wr_en  output  1  instruction memory write strobe.
- wr_addr  output  addr_w  write address.
- wr_data  output  instr_width  encoded word.
- err  output  1  one-cycle pulse; accepted instruction was illegal.
- err_count  output  8  saturating count of illegal instructions.
- word_count  output  addr_w+1  words written since start.
- done  output  1  high in DONE.
- overflow  output  1  sticky; memory filled before HALT.

Behaviour:
- Reset (async): state=IDLE. in_ready, wr_en, err, done and overflow are 0. wr_addr, wr_data, err_count and word_count are 0.
- States:
  - IDLE --start--> RUN.
  - RUN --HALT written, or non-HALT written at address imem_depth-1--> DONE.
  - DONE --start--> RUN.
  - start in RUN is ignored.
- Handshake:
  - in_ready = (state==RUN).
  - A transfer occurs when in_valid && in_ready.
  - mnem and fields are sampled only on a transfer.
- Latency: a transfer in cycle N gives wr_en=1 with wr_data and wr_addr in cycle N+1. wr_en is a one-cycle pulse per legal word.
- Full throughput: one word per cycle. wr_addr increments after each write; word_count increments with each write.
- start: in the start cycle, wr_addr<=base_addr, word_count<=0, overflow<=0 and done<=0. err_count is not cleared by start; only reset clears it.
- Encoding, op=[8:6]:
  - AND/SLT/OR/JR: 000, [5:4]=rs-4, [3:2]=rt, [1:0]=0/1/2/3.
  - LW/SW: 001, [5:4]=rs-4, [3:2]=rt, [1:0]=0/1.
  - ADD: 010, [5:4]=rs-4, [3:2]=rt, [1:0]=rd-8.
  - ADDI: 011, [5:4]=rs-4, [3:2]=imm[1:0], [1:0]=rd.
  - TR1: 100, [5:3]=rd, [2:0]=rs-4.
  - TR2: 101, [5:3]=rs, [2:0]=rd-4.
  - HALT: 9'b111_000000.
- Legal ranges:
  - rs 4..7 and rt 0..3 for opcodes 000/001/010/011.
  - ADD: rd 8..11.
  - ADDI: imm 0..3, rd 0..3.
  - TR1: rd 0..7, rs 4..11.
  - TR2: rs 0..7, rd 4..11.
  - Fields unused by an opcode are don't-care and never cause an error.
- Illegal instruction (bad mnem or out-of-range field): still accepted. In cycle N+1, err=1 and err_count+1 (saturating at 255). No write; wr_addr and word_count are unchanged. Stays in RUN.
- Full: a legal non-HALT word written at imem_depth-1 sets overflow=1 and goes to DONE; wr_addr does not wrap. HALT written at imem_depth-1 goes to DONE with overflow=0.
- DONE: in_ready=0, done=1. Outputs hold, except wr_en=0.
- Reset mid-RUN: immediate return to IDLE. Any pending write is dropped.

Test Plan:
- Reset, start with base_addr=0x10; send ADD rs=5 rt=2 rd=9 -> next cycle wr_en=1, wr_addr=0x10, wr_data=0x099, word_count=1.
- Back-to-back AND rs=6 rt=1, ADDI rs=4 imm=3 rd=2, TR1 rd=3 rs=10, HALT -> four consecutive writes 0x024, 0x0CE, 0x11E, 0x1C0 at 0x00..0x03; then done=1, in_ready=0, overflow=0.
- ADD rs=2 rt=0 rd=9 (rs out of range), then mnem=12 -> two err pulses, err_count=2, no wr_en, next legal word still written at the original address.
- start with base_addr=imem_depth-2; send OR, SLT, AND -> 0x002 and 0x001 written at 254 and 255; overflow=1, done=1, in_ready=0; the third instruction is never accepted.
- Assert reset asynchronously in the cycle after a transfer -> no wr_en; all outputs 0 in that cycle; a following start restarts cleanly with err_count=0.
- Hold in_valid low in RUN for 5 cycles -> no writes, wr_addr stable; start pulsed during RUN has no effect.

Source files
------------

// File: rtl/instr_encoder.sv
// Sequential instruction encoder: range-checks symbolic instructions, packs them
// into 9-bit words and streams them into instruction memory at rising addresses.
module instr_encoder #(
  parameter int num_regs    = 12,
  parameter int instr_width = 9,
  parameter int imem_depth  = 256,
  localparam int reg_w      = $clog2(num_regs),
  localparam int addr_w     = $clog2(imem_depth)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [addr_w-1:0]      base_addr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             mnem,
  input  logic [reg_w-1:0]       rs,
  input  logic [reg_w-1:0]       rt,
  input  logic [reg_w-1:0]       rd,
  input  logic [2:0]             imm,
  output logic                   wr_en,
  output logic [addr_w-1:0]      wr_addr,
  output logic [instr_width-1:0] wr_data,
  output logic                   err,
  output logic [7:0]             err_count,
  output logic [addr_w:0]        word_count,
  output logic                   done,
  output logic                   overflow
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [addr_w-1:0] last_addr = addr_w'(imem_depth - 1);

  state_t                   state, state_next;
  logic [addr_w-1:0]        ptr;
  logic                     xfer;
  logic                     legal;
  logic                     is_halt;
  logic                     rs_low;
  logic                     rt_low;
  logic [instr_width-1:0]   word;

  assign in_ready = (state == RUN);
  assign done     = (state == DONE);
  assign xfer     = in_valid && in_ready;

  // Field legality and packing; register offsets (rs-4, rd-8) reduce to low bits
  // because the legal ranges are aligned to the field widths.
  always_comb begin
    legal   = 1'b0;
    is_halt = 1'b0;
    word    = '0;
    rs_low  = (rs >= reg_w'(4)) && (rs <= reg_w'(7));
    rt_low  = (rt <= reg_w'(3));
    case (mnem)
      4'd0, 4'd1, 4'd2, 4'd3: begin
        legal = rs_low && rt_low;
        word  = {3'b000, rs[1:0], rt[1:0], mnem[1:0]};
      end
      4'd4, 4'd5: begin
        legal = rs_low && rt_low;
        word  = {3'b001, rs[1:0], rt[1:0], 1'b0, mnem[0]};
      end
      4'd6: begin
        legal = rs_low && rt_low && (rd >= reg_w'(8)) && (rd <= reg_w'(11));
        word  = {3'b010, rs[1:0], rt[1:0], rd[1:0]};
      end
      4'd7: begin
        legal = rs_low && (imm <= 3'd3) && (rd <= reg_w'(3));
        word  = {3'b011, rs[1:0], imm[1:0], rd[1:0]};
      end
      4'd8: begin
        legal = (rd <= reg_w'(7)) && (rs >= reg_w'(4)) && (rs <= reg_w'(11));
        word  = {3'b100, rd[2:0], rs[2:0] - 3'd4};
      end
      4'd9: begin
        legal = (rs <= reg_w'(7)) && (rd >= reg_w'(4)) && (rd <= reg_w'(11));
        word  = {3'b101, rs[2:0], rd[2:0] - 3'd4};
      end
      4'd15: begin
        legal   = 1'b1;
        is_halt = 1'b1;
        word    = 9'h1C0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (xfer && legal && (is_halt || ptr == last_addr)) state_next = DONE;
      DONE:    if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // ptr is the next free address; wr_addr shows the address of the most recent write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr        <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      err        <= 1'b0;
      err_count  <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      err   <= 1'b0;
      if (start && state != RUN) begin
        ptr        <= base_addr;
        wr_addr    <= base_addr;
        word_count <= '0;
        overflow   <= 1'b0;
      end else if (xfer) begin
        if (legal) begin
          wr_en      <= 1'b1;
          wr_addr    <= ptr;
          wr_data    <= word;
          word_count <= word_count + (addr_w+1)'(1);
          if (!is_halt && ptr == last_addr) overflow <= 1'b1;
          if (ptr != last_addr) ptr <= ptr + addr_w'(1);
        end else begin
          err <= 1'b1;
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios then random traffic,
// compared cycle by cycle against an arithmetic reference model.
module tb_instr_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] base_addr;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] mnem;
  logic [3:0] rs, rt, rd;
  logic [2:0] imm;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [8:0] wr_data;
  logic       err;
  logic [7:0] err_count;
  logic [8:0] word_count;
  logic       done;
  logic       overflow;

  int pass_count = 0;
  int total_count = 0;

  // reference model state
  bit m_running, m_done, m_overflow, m_wr_en, m_err;
  int m_ptr, m_wr_addr, m_wr_data, m_err_count, m_word_count;

  instr_encoder dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .mnem(mnem),
    .rs(rs), .rt(rt), .rd(rd), .imm(imm),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .err(err), .err_count(err_count), .word_count(word_count),
    .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_count++;
    assert (obs === exp) pass_count++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic void model_encode(input int m, input int r_s, input int r_t,
                                       input int r_d, input int im,
                                       output bit legal, output int word, output bit halt);
    bit rs_ok = (r_s >= 4 && r_s <= 7);
    bit rt_ok = (r_t <= 3);
    legal = 0; word = 0; halt = 0;
    case (m)
      0, 1, 2, 3: begin legal = rs_ok && rt_ok; word = (r_s-4)*16 + r_t*4 + m; end
      4, 5:       begin legal = rs_ok && rt_ok; word = 64 + (r_s-4)*16 + r_t*4 + (m-4); end
      6: begin
        legal = rs_ok && rt_ok && r_d >= 8 && r_d <= 11;
        word  = 128 + (r_s-4)*16 + r_t*4 + (r_d-8);
      end
      7: begin
        legal = rs_ok && im <= 3 && r_d <= 3;
        word  = 192 + (r_s-4)*16 + im*4 + r_d;
      end
      8: begin
        legal = r_d <= 7 && r_s >= 4 && r_s <= 11;
        word  = 256 + r_d*8 + (r_s-4);
      end
      9: begin
        legal = r_s <= 7 && r_d >= 4 && r_d <= 11;
        word  = 320 + r_s*8 + (r_d-4);
      end
      15: begin legal = 1; halt = 1; word = 448; end
      default: ;
    endcase
  endfunction

  task automatic model_reset();
    m_running = 0; m_done = 0; m_overflow = 0; m_wr_en = 0; m_err = 0;
    m_ptr = 0; m_wr_addr = 0; m_wr_data = 0; m_err_count = 0; m_word_count = 0;
  endtask

  task automatic check_all(input string tag);
    check_output({tag, ".wr_en"}, wr_en, m_wr_en);
    check_output({tag, ".wr_addr"}, wr_addr, m_wr_addr);
    check_output({tag, ".wr_data"}, wr_data, m_wr_data);
    check_output({tag, ".err"}, err, m_err);
    check_output({tag, ".err_count"}, err_count, m_err_count);
    check_output({tag, ".word_count"}, word_count, m_word_count);
    check_output({tag, ".done"}, done, m_done);
    check_output({tag, ".overflow"}, overflow, m_overflow);
    check_output({tag, ".in_ready"}, in_ready, m_running);
  endtask

  // One clock: drive inputs, advance, update the model, compare every output.
  task automatic apply_stimulus(input string tag, input bit v, input int m, input int r_s,
                                input int r_t, input int r_d, input int im,
                                input bit st, input int base);
    bit legal, halt, xfer;
    int word;
    in_valid = v; mnem = 4'(m); rs = 4'(r_s); rt = 4'(r_t); rd = 4'(r_d); imm = 3'(im);
    start = st; base_addr = 8'(base);
    check_output({tag, ".ready_pre"}, in_ready, m_running);
    xfer = v && m_running;
    @(posedge clk); #1;
    m_wr_en = 0; m_err = 0;
    if (st && !m_running) begin
      m_running = 1; m_done = 0; m_overflow = 0;
      m_ptr = base; m_wr_addr = base; m_word_count = 0;
    end else if (xfer) begin
      model_encode(m, r_s, r_t, r_d, im, legal, word, halt);
      if (legal) begin
        m_wr_en = 1; m_wr_addr = m_ptr; m_wr_data = word; m_word_count++;
        if (halt || m_ptr == 255) begin
          m_running = 0; m_done = 1;
          if (!halt) m_overflow = 1;
        end
        if (m_ptr != 255) m_ptr++;
      end else begin
        m_err = 1;
        if (m_err_count < 255) m_err_count++;
      end
    end
    in_valid = 0; start = 0;
    check_all(tag);
  endtask

  initial begin
    reset = 1; start = 0; base_addr = 0; in_valid = 0;
    mnem = 0; rs = 0; rt = 0; rd = 0; imm = 0;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk); reset = 0;
    @(negedge clk);

    // single ADD at base 0x10
    apply_stimulus("start10", 0, 0, 0, 0, 0, 0, 1, 8'h10);
    apply_stimulus("add", 1, 6, 5, 2, 9, 0, 0, 0);
    check_output("add.data_lit", wr_data, 9'h099);
    check_output("add.addr_lit", wr_addr, 8'h10);
    apply_stimulus("halt10", 1, 15, 0, 0, 0, 0, 0, 0);

    // back-to-back burst ending in HALT
    apply_stimulus("start00", 0, 0, 0, 0, 0, 0, 1, 0);
    apply_stimulus("and", 1, 0, 6, 1, 0, 0, 0, 0);
    check_output("and.data_lit", wr_data, 9'h024);
    apply_stimulus("addi", 1, 7, 4, 0, 2, 3, 0, 0);
    check_output("addi.data_lit", wr_data, 9'h0CE);
    apply_stimulus("tr1", 1, 8, 10, 0, 3, 0, 0, 0);
    check_output("tr1.data_lit", wr_data, 9'h11E);
    apply_stimulus("halt", 1, 15, 0, 0, 0, 0, 0, 0);
    check_output("halt.data_lit", wr_data, 9'h1C0);
    check_output("halt.addr_lit", wr_addr, 8'h03);
    apply_stimulus("done_hold", 1, 0, 4, 0, 0, 0, 0, 0);

    // illegal instructions do not consume an address
    apply_stimulus("start20", 0, 0, 0, 0, 0, 0, 1, 8'h20);
    apply_stimulus("bad_rs", 1, 6, 2, 0, 9, 0, 0, 0);
    apply_stimulus("bad_mnem", 1, 12, 5, 1, 8, 0, 0, 0);
    check_output("bad.err_count_lit", err_count, 8'd2);
    apply_stimulus("after_bad", 1, 4, 7, 3, 0, 0, 0, 0);
    check_output("after_bad.addr_lit", wr_addr, 8'h20);
    apply_stimulus("halt20", 1, 15, 0, 0, 0, 0, 0, 0);

    // memory fills before HALT
    apply_stimulus("start254", 0, 0, 0, 0, 0, 0, 1, 254);
    apply_stimulus("or254", 1, 2, 4, 0, 0, 0, 0, 0);
    check_output("or254.data_lit", wr_data, 9'h002);
    apply_stimulus("slt255", 1, 1, 4, 0, 0, 0, 0, 0);
    check_output("slt255.ovf_lit", overflow, 1'b1);
    apply_stimulus("and_blocked", 1, 0, 4, 0, 0, 0, 0, 0);

    // HALT landing exactly on the last address
    apply_stimulus("start255", 0, 0, 0, 0, 0, 0, 1, 255);
    apply_stimulus("halt255", 1, 15, 0, 0, 0, 0, 0, 0);
    check_output("halt255.ovf_lit", overflow, 1'b0);

    // idle RUN cycles with a stray start
    apply_stimulus("start40", 0, 0, 0, 0, 0, 0, 1, 8'h40);
    for (int i = 0; i < 5; i++) apply_stimulus("idle", 0, 6, 5, 2, 9, 0, (i == 2), 8'h80);
    apply_stimulus("post_idle", 1, 9, 3, 0, 6, 0, 0, 0);
    check_output("post_idle.addr_lit", wr_addr, 8'h40);

    // async reset in the cycle after a transfer drops the write
    apply_stimulus("pre_reset", 1, 5, 6, 2, 0, 0, 0, 0);
    #2 reset = 1;
    model_reset();
    #1 check_all("mid_reset");
    #1 reset = 0;
    apply_stimulus("restart", 0, 0, 0, 0, 0, 0, 1, 8'h08);
    check_output("restart.err_count_lit", err_count, 8'd0);
    apply_stimulus("restart_w", 1, 0, 7, 3, 0, 0, 0, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      int m, r_s, r_t, r_d, im, base;
      bit v, st;
      m = ($urandom_range(0, 19) == 0) ? 15 : $urandom_range(0, 14);
      r_s = $urandom_range(0, 12);
      r_t = (m == 7) ? $urandom_range(0, 3) : $urandom_range(0, 5);
      r_d = $urandom_range(0, 12);
      im = $urandom_range(0, 4);
      v = ($urandom_range(0, 3) != 0);
      st = m_running ? ($urandom_range(0, 15) == 0) : 1'b1;
      base = $urandom_range(0, 1) ? $urandom_range(240, 255) : $urandom_range(0, 255);
      apply_stimulus("rand", v, m, r_s, r_t, r_d, im, st, base);
    end

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
